// File: rtl/sifh_ctrl.sv
// Two-pass (coarse/fine) histogram sequencer for the SiFH dToF datapath.
// A coarse pass locates the peak bin. A fine pass then runs inside a window
// of +/-GUARD bins around that peak and reports the fine peak and the tof.
//
// state  | meaning
// IDLE   | waiting for start; thresholds and results hold their values
// CLEAR  | clear-on-read sweep of every bin, read data discarded
// COARSE | accumulate with his_num=0 until N_COARSE laser shots
// SCAN_C | sweep the coarse histogram for its peak (also empties memory)
// CONFIG | thresholds valid; his_num is raised on leaving this state
// FINE   | accumulate with his_num=1 until N_FINE laser shots
// SCAN_F | sweep the fine histogram for its peak
// DONE   | one-cycle done pulse with results valid
module sifh_ctrl #(
    parameter int NP        = 16,
    parameter int NB        = 8,
    parameter int CW        = 16,
    parameter int N_COARSE  = 1024,
    parameter int N_FINE    = 1024,
    parameter int GUARD     = 1,
    parameter int MIN_COUNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          laser_sync,
    output logic          acc_en,
    output logic          his_num,
    output logic [NP-1:0] th_minus,
    output logic [NP-1:0] th_positive,
    output logic [NP-1:0] delta,
    output logic          rd_en,
    output logic [NB-1:0] rd_addr,
    input  logic [CW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          no_target,
    output logic [NB-1:0] coarse_bin,
    output logic [NB-1:0] fine_bin,
    output logic [CW-1:0] peak_count,
    output logic [NP-1:0] tof
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, COARSE, SCAN_C, CONFIG, FINE, SCAN_F, DONE
    } state_t;

    localparam int S    = NP - NB;
    localparam int NMAX = (N_COARSE > N_FINE) ? N_COARSE : N_FINE;
    localparam int SW   = $clog2(NMAX + 1);
    localparam logic [NB:0]   LAST_ADDR = (NB+1)'((1 << NB) - 1);
    localparam logic [NB:0]   SCAN_END  = (NB+1)'(1 << NB);
    localparam logic [SW-1:0] NC_LD     = SW'(N_COARSE - 1);
    localparam logic [SW-1:0] NF_LD     = SW'(N_FINE - 1);

    state_t          state, state_nx;
    logic [NB:0]     addr_cnt;
    logic [SW-1:0]   shot_cnt;
    logic            arm;
    logic [NB-1:0]   peak_bin;
    logic [CW-1:0]   peak_cnt;

    logic            scan, accum, cnt_ev, shot_tc, scan_end, clear_end, upd;
    logic [NB-1:0]   cand_bin;
    logic [CW-1:0]   cand_cnt;
    logic [NP:0]     hi_sum, hi_w, lo_w;
    logic [NP-1:0]   th_min_nx, th_pos_nx, tof_nx;

    // Shared decode, running peak candidate and window arithmetic.
    always_comb begin
        scan      = (state == SCAN_C) || (state == SCAN_F);
        accum     = (state == COARSE) || (state == FINE);
        // arm is low on the entry cycle so a coincident pulse is not counted
        cnt_ev    = laser_sync && arm && accum;
        shot_tc   = cnt_ev && (shot_cnt == '0);
        scan_end  = scan && (addr_cnt == SCAN_END);
        clear_end = (state == CLEAR) && (addr_cnt == LAST_ADDR);
        // rd_data belongs to the address issued one cycle earlier
        upd       = scan && (addr_cnt != '0) && (rd_data > peak_cnt);
        cand_bin  = upd ? (addr_cnt[NB-1:0] - NB'(1)) : peak_bin;
        cand_cnt  = upd ? rd_data : peak_cnt;
        // window math in NP+1 bits so the upper edge cannot wrap
        hi_sum    = (NP+1)'(cand_bin) + (NP+1)'(1 + GUARD);
        hi_w      = (hi_sum << S) - (NP+1)'(1);
        th_pos_nx = (hi_sum > (NP+1)'(1 << NB)) ? '1 : hi_w[NP-1:0];
        lo_w      = ((NP+1)'(cand_bin) - (NP+1)'(GUARD)) << S;
        th_min_nx = ((NP+1)'(cand_bin) < (NP+1)'(GUARD)) ? '0 : lo_w[NP-1:0];
        tof_nx    = delta + (NP'(cand_bin) << S);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)     state_nx = CLEAR;
            CLEAR:   if (clear_end) state_nx = COARSE;
            COARSE:  if (shot_tc)   state_nx = SCAN_C;
            SCAN_C:  if (scan_end)  state_nx = (cand_cnt < CW'(MIN_COUNT)) ? DONE : CONFIG;
            CONFIG:                 state_nx = FINE;
            FINE:    if (shot_tc)   state_nx = SCAN_F;
            SCAN_F:  if (scan_end)  state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and the sweep address.
    always_comb begin
        acc_en  = accum;
        rd_en   = (state == CLEAR) || (scan && !addr_cnt[NB]);
        rd_addr = rd_en ? addr_cnt[NB-1:0] : '0;
        busy    = (state != IDLE);
        done    = (state == DONE);
    end

    // Counters, peak tracking, thresholds and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt    <= '0;
            shot_cnt    <= '0;
            arm         <= 1'b0;
            peak_bin    <= '0;
            peak_cnt    <= '0;
            his_num     <= 1'b0;
            th_minus    <= '0;
            th_positive <= '1;
            delta       <= '0;
            no_target   <= 1'b0;
            coarse_bin  <= '0;
            fine_bin    <= '0;
            peak_count  <= '0;
            tof         <= '0;
        end else begin
            if (state_nx != state)
                addr_cnt <= '0;
            else if ((state == CLEAR) || scan)
                addr_cnt <= addr_cnt + (NB+1)'(1);

            arm <= accum;

            if (state_nx == COARSE && state != COARSE)
                shot_cnt <= NC_LD;
            else if (state_nx == FINE && state != FINE)
                shot_cnt <= NF_LD;
            else if (cnt_ev && shot_cnt != '0)
                shot_cnt <= shot_cnt - SW'(1);

            if (scan) begin
                peak_bin <= cand_bin;
                peak_cnt <= cand_cnt;
            end else begin
                peak_bin <= '0;
                peak_cnt <= '0;
            end

            if (state == IDLE && start) begin
                no_target  <= 1'b0;
                coarse_bin <= '0;
                fine_bin   <= '0;
                peak_count <= '0;
                tof        <= '0;
            end

            if (state == SCAN_C && scan_end) begin
                coarse_bin <= cand_bin;
                if (cand_cnt < CW'(MIN_COUNT)) begin
                    no_target <= 1'b1;
                end else begin
                    th_minus    <= th_min_nx;
                    th_positive <= th_pos_nx;
                    delta       <= th_min_nx;
                end
            end

            if (state == SCAN_F && scan_end) begin
                fine_bin   <= cand_bin;
                peak_count <= cand_cnt;
                tof        <= tof_nx;
            end

            if (state == CONFIG)
                his_num <= 1'b1;
            else if (state == DONE)
                his_num <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sifh_ctrl.sv
// Directed bench for sifh_ctrl with a clear-on-read histogram memory model.
module tb_sifh_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        laser_sync = 1'b0;
    logic        acc_en, his_num, rd_en, busy, done, no_target;
    logic [15:0] th_minus, th_positive, delta, tof, peak_count;
    logic [7:0]  rd_addr, coarse_bin, fine_bin;
    logic [15:0] rd_data = '0;

    logic [15:0] mem [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_val = '0;

    int n_chk = 0;
    int n_fail = 0;

    sifh_ctrl #(
        .NP(16), .NB(8), .CW(16), .N_COARSE(8), .N_FINE(8), .GUARD(1), .MIN_COUNT(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .laser_sync(laser_sync),
        .acc_en(acc_en), .his_num(his_num), .th_minus(th_minus),
        .th_positive(th_positive), .delta(delta), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .no_target(no_target), .coarse_bin(coarse_bin), .fine_bin(fine_bin),
        .peak_count(peak_count), .tof(tof)
    );

    always #5 clk = ~clk;

    // Histogram memory: registered clear-on-read port plus a bench load port.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data      <= mem[rd_addr];
            mem[rd_addr] <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_val;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] v);
        ld_en = 1'b1; ld_addr = a; ld_val = v;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_acc"}, acc_en, 1'b0);
        check({tag, "_his"}, his_num, 1'b0);
        check({tag, "_thm"}, th_minus, 16'h0000);
        check({tag, "_thp"}, th_positive, 16'hFFFF);
        check({tag, "_delta"}, delta, 16'h0000);
        check({tag, "_rden"}, rd_en, 1'b0);
        check({tag, "_rdaddr"}, rd_addr, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_nt"}, no_target, 1'b0);
        check({tag, "_cbin"}, coarse_bin, 8'h00);
        check({tag, "_fbin"}, fine_bin, 8'h00);
        check({tag, "_pk"}, peak_count, 16'h0000);
        check({tag, "_tof"}, tof, 16'h0000);
    endtask

    task automatic wait_acc(input string tag);
        for (int i = 0; i < 600 && !acc_en; i++) tick();
        check({tag, "_acc_rise"}, acc_en, 1'b1);
    endtask

    // Eight laser shots, two cycles apart; acc_en must drop right after the last.
    task automatic shots(input string tag);
        for (int i = 0; i < 8; i++) begin
            laser_sync = 1'b1;
            tick();
            laser_sync = 1'b0;
            if (i == 6) check({tag, "_acc_hold"}, acc_en, 1'b1);
            if (i == 7) check({tag, "_acc_fall"}, acc_en, 1'b0);
            tick();
        end
    endtask

    task automatic wait_his(input string tag, input logic [15:0] thm, input logic [15:0] thp);
        logic [15:0] pm, pp, pd;
        pm = th_minus; pp = th_positive; pd = delta;
        for (int i = 0; i < 600 && !his_num; i++) begin
            pm = th_minus; pp = th_positive; pd = delta;
            tick();
        end
        check({tag, "_his_rise"}, his_num, 1'b1);
        check({tag, "_fine_acc"}, acc_en, 1'b1);
        check({tag, "_thm_pre"}, pm, thm);
        check({tag, "_thp_pre"}, pp, thp);
        check({tag, "_delta_pre"}, pd, thm);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 600 && !done; i++) tick();
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic after_done(input string tag);
        tick();
        check({tag, "_done_fall"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_his_idle"}, his_num, 1'b0);
    endtask

    // Full target run: coarse peak cb (count cc), fine peak fb (count fc).
    task automatic full_run(input string tag, input logic [7:0] cb, input logic [15:0] cc,
                            input logic [7:0] fb, input logic [15:0] fc,
                            input logic [15:0] thm, input logic [15:0] thp,
                            input logic [15:0] exp_tof);
        pulse_start();
        wait_acc(tag);
        check({tag, "_his0"}, his_num, 1'b0);
        load(cb, cc);
        tick();
        shots(tag);
        wait_his(tag, thm, thp);
        check({tag, "_cbin"}, coarse_bin, cb);
        load(fb, fc);
        shots({tag, "_f"});
        wait_done(tag);
        check({tag, "_fbin"}, fine_bin, fb);
        check({tag, "_pk"}, peak_count, fc);
        check({tag, "_tof"}, tof, exp_tof);
        check({tag, "_nt"}, no_target, 1'b0);
        after_done(tag);
    endtask

    initial begin
        int dones;
        logic saw_his, saw_acc;

        tick(); tick(); tick();
        check_reset_vals("rst0");
        rst = 1'b0;
        tick();

        // Main case: peak 0x40 plus small clutter, fine peak 0x13.
        pulse_start();
        wait_acc("a");
        check("a_his0", his_num, 1'b0);
        load(8'h40, 16'd50);
        load(8'h10, 16'd3);
        load(8'h80, 16'd2);
        load(8'hFF, 16'd3);
        shots("a");
        wait_his("a", 16'h3F00, 16'h41FF);
        check("a_cbin", coarse_bin, 8'h40);
        check("a_delta", delta, 16'h3F00);
        load(8'h13, 16'd20);
        load(8'h14, 16'd5);
        shots("a_f");
        wait_done("a");
        check("a_fbin", fine_bin, 8'h13);
        check("a_pk", peak_count, 16'd20);
        check("a_tof", tof, 16'h5200);
        after_done("a");

        // Edge bins: lower clamp and upper clamp of the window.
        full_run("lo", 8'h00, 16'd9, 8'h01, 16'd6, 16'h0000, 16'h01FF, 16'h0100);
        full_run("hi", 8'hFF, 16'd7, 8'h01, 16'd5, 16'hFE00, 16'hFFFF, 16'hFF00);

        // Equal peaks: lowest address wins.
        pulse_start();
        wait_acc("tie");
        load(8'h10, 16'd30);
        load(8'h20, 16'd30);
        shots("tie");
        wait_his("tie", 16'h0F00, 16'h11FF);
        check("tie_cbin", coarse_bin, 8'h10);
        load(8'h10, 16'd8);
        shots("tie_f");
        wait_done("tie");
        check("tie_tof", tof, 16'h1F00);
        after_done("tie");

        // Peak exactly MIN_COUNT still counts as a target.
        full_run("min", 8'h30, 16'd4, 8'h02, 16'd1, 16'h2F00, 16'h31FF, 16'h3100);

        // No target: all bins at most 3.
        pulse_start();
        check("nt_clear_tof", tof, 16'h0000);
        check("nt_clear_fbin", fine_bin, 8'h00);
        wait_acc("nt");
        load(8'h05, 16'd3);
        load(8'h90, 16'd3);
        load(8'hFF, 16'd2);
        shots("nt");
        saw_his = 1'b0; saw_acc = 1'b0; dones = 0;
        for (int i = 0; i < 600 && dones == 0; i++) begin
            tick();
            if (his_num) saw_his = 1'b1;
            if (acc_en) saw_acc = 1'b1;
            if (done) dones++;
        end
        check("nt_nt", no_target, 1'b1);
        check("nt_cbin", coarse_bin, 8'h05);
        check("nt_pk", peak_count, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dones++;
            if (acc_en) saw_acc = 1'b1;
        end
        check("nt_done_cnt", dones, 1);
        check("nt_no_his", saw_his, 1'b0);
        check("nt_no_fine", saw_acc, 1'b0);
        check("nt_nt_hold", no_target, 1'b1);
        check("nt_thm_hold", th_minus, 16'h2F00);

        // Reset during FINE, leaving data in the histogram.
        pulse_start();
        wait_acc("r");
        load(8'h40, 16'd50);
        shots("r");
        wait_his("r", 16'h3F00, 16'h41FF);
        load(8'h22, 16'd40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rmid");
        tick();

        // Start during a run is ignored; stale bin 0x22 must be cleared.
        pulse_start();
        wait_acc("s");
        tick();
        pulse_start();
        check("s_busy", busy, 1'b1);
        check("s_acc_kept", acc_en, 1'b1);
        load(8'h80, 16'd12);
        shots("s");
        wait_his("s", 16'h7F00, 16'h81FF);
        check("s_cbin", coarse_bin, 8'h80);
        load(8'h7F, 16'd6);
        shots("s_f");
        wait_done("s");
        check("s_fbin", fine_bin, 8'h7F);
        check("s_pk", peak_count, 16'd6);
        check("s_tof", tof, 16'hFE00);
        after_done("s");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sifh_ctrl.md
# sifh_ctrl

Two-pass (coarse/fine) histogram sequencer for the SiFH dToF datapath. Runs a coarse accumulation with the data filter in pass 0 and finds the coarse peak bin from the histogram memory. It then programs the filter window (`th_minus`, `th_positive`, `delta`), runs a fine accumulation with the filter in pass 1, and reports the fine peak and the reconstructed time-of-flight. It owns the histogram memory read port and the accumulate enable.

## Interface
- `NP`, 16: timestamp width; matches the data filter's `roughData`.
- `NB`, 8: histogram bin-address width; `S = NP-NB` is the bin shift.
- `CW`, 16: histogram count width.
- `N_COARSE`, 1024: laser shots per coarse pass.
- `N_FINE`, 1024: laser shots per fine pass.
- `GUARD`, 1: guard bins on each side of the coarse peak.
- `MIN_COUNT`, 4: minimum coarse peak count that counts as a target.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; ignored unless in IDLE.
- `laser_sync`  in  1  one-cycle pulse per laser shot.
- `acc_en`  out  1  histogram accumulate enable.
- `his_num`  out  1  filter pass select: 0 = coarse, 1 = fine.
- `th_minus`, `th_positive`, `delta`  out  NP  filter window and offset.
- `rd_en`  out  1  histogram read, clear-on-read.
- `rd_addr`  out  NB  read address.
- `rd_data`  in  CW  read data, valid exactly 1 cycle after `rd_en`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `no_target`  out  1  coarse peak below `MIN_COUNT`; valid from `done` until the next `start`.
- `coarse_bin`, `fine_bin`  out  NB  peak bins.
- `peak_count`  out  CW  fine-pass peak count.
- `tof`  out  NP  `delta + (fine_bin << S)`, NP-bit.

## Operation
- States are IDLE, CLEAR, COARSE, SCAN_C, CONFIG, FINE, SCAN_F, DONE.
- IDLE -> CLEAR on `start`. The `start` cycle clears `no_target` and the result registers.
- CLEAR issues `rd_en` on addresses 0..2^NB-1, one per cycle, and discards the data. This empties the memory. Then -> COARSE.
- COARSE holds `acc_en`=1 and `his_num`=0. The shot counter counts `laser_sync` pulses. On the `N_COARSE`-th pulse `acc_en` drops the next cycle, and the state goes -> SCAN_C.
- SCAN_C and SCAN_F sweep addresses 0..2^NB-1 and compare each `rd_data` one cycle later.
  - Replace the peak only if strictly greater, so ties go to the lowest address.
  - Initial peak is bin 0 with count 0.
  - Clear-on-read leaves the memory empty, so no CLEAR is needed between passes.
- After SCAN_C:
  - If peak count < `MIN_COUNT`: `no_target`=1, go -> DONE, skip the fine pass, `his_num` stays 0.
  - Otherwise go -> CONFIG.
- CONFIG lasts 1 cycle, with p = `coarse_bin`:
  - `th_minus` = (p-GUARD)<<S, clamped to 0 when p < GUARD.
  - `th_positive` = ((p+1+GUARD)<<S)-1, clamped to 2^NP-1 when p+1+GUARD > 2^NB.
  - `delta` = `th_minus`.
  - Compute in NP+1 bits before clamping.
  - `his_num` goes to 1. Then -> FINE.
- FINE behaves like COARSE but uses `N_FINE`. Then -> SCAN_F.
- After SCAN_F: latch `fine_bin`, `peak_count`, `tof`, then -> DONE.
- DONE pulses `done` for 1 cycle, -> IDLE.
- IDLE: `his_num` returns to 0. `th_*`, `delta` and result outputs hold their last values.
- A `laser_sync` coincident with state entry into COARSE or FINE is not counted. Counting starts the cycle after entry.
- `start` while busy: ignored.

## Timing
- Reset values:
  - All outputs are 0, except `th_positive` = 2^NP-1.
  - State is IDLE and counters are 0.
- `rst` mid-operation:
  - The state machine is in IDLE and all outputs are at their reset values on the cycle after `rst` is sampled high.
  - The histogram is not cleared. The next run's CLEAR handles that.
- CLEAR: 2^NB cycles.
- Each scan is 2^NB+1 cycles, including the final read-latency cycle.
- `acc_en` rises on the cycle the machine enters COARSE or FINE.
- `acc_en` falls on the cycle after the terminal `laser_sync`.
- `th_minus`, `th_positive` and `delta` become stable the cycle before `his_num` rises and before FINE `acc_en` rises.
- `done` and the result outputs update in the same cycle.

## Test plan
Common settings: NP=16, NB=8, GUARD=1, MIN_COUNT=4, N_COARSE=N_FINE=8.
- Coarse histogram bin 0x40=50, others ≤3 -> `coarse_bin`=0x40, `th_minus`=0x3F00, `th_positive`=0x41FF, `delta`=0x3F00, `his_num` rises 1 cycle after the thresholds settle.
- Coarse peak at bin 0x00, then a separate run with peak at 0xFF -> windows 0x0000..0x01FF and 0xFE00..0xFFFF (clamped), with no wrap-around.
- Coarse bins 0x10=30 and 0x20=30 -> `coarse_bin`=0x10.
- All coarse bins ≤3 -> `no_target`=1, one `done` pulse, `his_num` never 1, FINE never entered.
- Fine peak bin 0x13 with `delta`=0x3F00 -> `tof`=0x5200, `fine_bin`=0x13, `done` 1 cycle.
- `rst` during FINE -> all outputs at reset values the next cycle; `start` in the middle of a run is ignored; a following `start` completes a full run correctly.
